// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default width
// and the counter-width helper.
package bit_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold the value WIDTH, so it never wraps inside one operation.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder (module fa_cell) built from nine 2-input NAND gates.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic n1, n2, n3, x, n5, n6, n7;

  // First half adder: x = a ^ b, n1 = ~(a & b)
  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign x  = ~(n2 & n3);

  // Second half adder on (x, ci); carry merges both half-adder carries
  assign n5 = ~(x & ci);
  assign n6 = ~(x & n5);
  assign n7 = ~(ci & n5);
  assign s  = ~(n6 & n7);
  assign co = ~(n5 & n1);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one result bit per clock through a single fa_cell.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] b_load;
  logic             carry, c_load;
  logic [CW-1:0]    cnt;
  logic             load, fa_s, fa_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)      state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    load      = (state == IDLE) && in_valid;
  end

`ifdef SERIAL_SUB_EN
  // a - b computed as a + ~b + 1; cin has no meaning in this mode
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result fills from the MSB end so after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {fa_s, res_sr[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
    end
  end

  assign sum  = res_sr;
  assign cout = carry;

endmodule
